sram_responder: RTL
===================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001: Parameter ADDR_W, default 18: number of implemented word-address bits. The array holds 2^ADDR_W words of 16 bits each.
REQ-002: Parameter CNT_W, default 16: width of the access counters.
REQ-003: Clocking and reset are fixed: one clock, and reset is asynchronous and active-high.
REQ-004: clk  input  1  sole clock; all state updates on posedge.
REQ-005: rst  input  1  asynchronous active-high reset.
REQ-006: SRAM_ADDRESS  input  18  word address from the controller.
REQ-007: SRAM_DATA  inout  16  bidirectional data bus; driven only during reads, otherwise Z.
REQ-008: SRAM_WE_N  input  1  write enable, active-low.
REQ-009: SRAM_CE_N  input  1  chip enable, active-low.
REQ-010: SRAM_OE_N  input  1  output enable, active-low.
REQ-011: SRAM_UB_N  input  1  upper-byte lane enable [15:8], active-low.
REQ-012: SRAM_LB_N  input  1  lower-byte lane enable [7:0], active-low.
REQ-013: init_done  output  1  high once the array clear has finished.
REQ-014: wr_count  output  CNT_W  number of accepted write cycles.
REQ-015: rd_count  output  CNT_W  number of accepted read cycles.
REQ-016: contention  output  1  sticky flag: the block drove the bus in a cycle where a write was applied.

Function
REQ-017: The FSM SHALL have two states, INIT and SERVE. Reset enters INIT with the clear pointer at 0.
REQ-018: INIT SHALL write 0x0000 to the word at the clear pointer each cycle, then increment the pointer.
- At pointer = 2^ADDR_W-1, the FSM moves to SERVE on the next edge.
- INIT therefore lasts exactly 2^ADDR_W cycles.
REQ-019: init_done SHALL be 0 in INIT and 1 in SERVE. It is registered.
REQ-020: In INIT, all pin activity SHALL be ignored:
- no array writes from the pins;
- no counter updates;
- the bus stays Z.
REQ-021: Word index SHALL be SRAM_ADDRESS[ADDR_W-1:0]. Upper bits are ignored, so aliasing is intended.
REQ-022: A write cycle is a posedge in SERVE with CE_N=0 and WE_N=0.
- The lower byte is updated iff LB_N=0; the upper byte iff UB_N=0.
- Disabled lanes keep their value.
- OE_N is ignored for writes.
REQ-023: A read cycle is a posedge in SERVE with CE_N=0, WE_N=1 and OE_N=0.
- At that edge the block SHALL register the addressed word, plus lane enables drv_lo=~LB_N and drv_hi=~UB_N.
- Read latency is 1 cycle: data is valid on the bus from that edge until the next edge.
REQ-024: Bus drive SHALL be per lane:
- [7:0] carries the registered word's low byte when drv_lo=1, otherwise Z;
- [15:8] likewise with drv_hi.
- When the most recent edge was not a read cycle, both drive enables SHALL be 0.
REQ-025: Read-after-write to the same address in consecutive cycles SHALL return the newly written data. The array write and the read register are ordered write-first.
REQ-026: wr_count SHALL increment by 1 per write cycle, even when both lanes are disabled. rd_count SHALL increment by 1 per read cycle. Both saturate at 2^CNT_W-1 and do not wrap.
REQ-027: contention SHALL set when, at a posedge, any drive enable is 1 and that edge is a write cycle. It stays set until rst.
REQ-028: Cycles with CE_N=1 SHALL:
- cause no array update;
- leave the counters unchanged;
- clear the drive enables at that edge.

Reset
REQ-029: While rst=1, asynchronously:
- state = INIT, clear pointer = 0, init_done = 0;
- wr_count = 0, rd_count = 0, contention = 0;
- drive enables = 0, so the bus is Z.
REQ-030: The array SHALL NOT be reset asynchronously. It is cleared only by the INIT sweep.
REQ-031: Reset asserted mid-INIT or mid-access SHALL abort the operation immediately. A full INIT sweep restarts from address 0 after release.

Verification (bench uses ADDR_W=4)
REQ-032: Scenario 1, reset then clear:
- Stimulus: pulse rst, then read address 5.
- Response: init_done is 0 for 16 cycles after release, then 1; the bus shows 0x0000 one cycle after the read edge; rd_count=1.
REQ-033: Scenario 2, full-word write and read:
- Stimulus: write 0xBEEF to address 3 with both lanes enabled, then read address 3 on the next cycle.
- Response: the bus shows 0xBEEF one cycle after the read edge; wr_count=1, rd_count=1.
REQ-034: Scenario 3, lane write:
- Stimulus: from scenario 2, write 0x1234 to address 3 with UB_N=1, then read with both lanes enabled.
- Response: 0xBE34. A read with LB_N=1 shows 0xBE on [15:8] and Z on [7:0].
REQ-035: Scenario 4, aliasing:
- Stimulus: write 0xA5A5 to address 0x00013, then read address 0x00003.
- Response: 0xA5A5.
REQ-036: Scenario 5, contention:
- Stimulus: a read edge at cycle n, then a write edge at cycle n+1.
- Response: contention=1 from edge n+1 onward, and it persists through idle cycles until rst.
REQ-037: Scenario 6, reset mid-INIT and saturation:
- Stimulus: assert rst at INIT cycle 8. Separately, with CNT_W=2, perform 5 writes.
- Response: after release, init_done rises 16 cycles later. wr_count stops at 3.

Source files
------------

// File: rtl/sram_responder.sv
// sram_responder: 16-bit SRAM pin-level responder; clears its array after reset,
// then serves byte-lane writes and 1-cycle-latency reads with access counters.
module sram_responder #(
    parameter int ADDR_W = 18,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [17:0]      SRAM_ADDRESS,
    inout  wire  [15:0]      SRAM_DATA,
    input  logic             SRAM_WE_N,
    input  logic             SRAM_CE_N,
    input  logic             SRAM_OE_N,
    input  logic             SRAM_UB_N,
    input  logic             SRAM_LB_N,
    output logic             init_done,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count,
    output logic             contention
);
    typedef enum logic {INIT, SERVE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_q, clr_d;
    logic                init_done_q, init_done_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic                cont_q, cont_d;
    logic                drv_lo_q, drv_lo_d;
    logic                drv_hi_q, drv_hi_d;
    logic [15:0]         rdata_q;
    logic [15:0]         mem [2**ADDR_W];
    logic [ADDR_W-1:0]   idx;
    logic                wr_cyc, rd_cyc;
    logic                unused_addr;

    // Upper address bits alias onto the implemented range.
    assign idx         = SRAM_ADDRESS[ADDR_W-1:0];
    assign unused_addr = ^SRAM_ADDRESS;
    assign wr_cyc      = (state_q == SERVE) && !SRAM_CE_N && !SRAM_WE_N;
    assign rd_cyc      = (state_q == SERVE) && !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;

    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        if (state_q == INIT) begin
            clr_d = clr_q + ADDR_W'(1);
            if (&clr_q) state_d = SERVE;
        end
        init_done_d = (state_d == SERVE);
        wr_cnt_d    = (wr_cyc && !(&wr_cnt_q)) ? wr_cnt_q + CNT_W'(1) : wr_cnt_q;
        rd_cnt_d    = (rd_cyc && !(&rd_cnt_q)) ? rd_cnt_q + CNT_W'(1) : rd_cnt_q;
        drv_lo_d    = rd_cyc && !SRAM_LB_N;
        drv_hi_d    = rd_cyc && !SRAM_UB_N;
        cont_d      = cont_q || (wr_cyc && (drv_lo_q || drv_hi_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            clr_q       <= '0;
            init_done_q <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            cont_q      <= 1'b0;
            drv_lo_q    <= 1'b0;
            drv_hi_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            init_done_q <= init_done_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            cont_q      <= cont_d;
            drv_lo_q    <= drv_lo_d;
            drv_hi_q    <= drv_hi_d;
        end
    end

    // The array is never reset; only the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (state_q == INIT) mem[clr_q] <= '0;
        if (wr_cyc && !SRAM_LB_N) mem[idx][7:0] <= SRAM_DATA[7:0];
        if (wr_cyc && !SRAM_UB_N) mem[idx][15:8] <= SRAM_DATA[15:8];
        if (rd_cyc) rdata_q <= mem[idx];
    end

    assign SRAM_DATA  = {drv_hi_q ? rdata_q[15:8] : 8'hzz, drv_lo_q ? rdata_q[7:0] : 8'hzz};
    assign init_done  = init_done_q;
    assign wr_count   = wr_cnt_q;
    assign rd_count   = rd_cnt_q;
    assign contention = cont_q;
endmodule
